// File: rtl/ndp_axis_pkg.sv
// Shared constants for the NDP operand interleaver: FSM encoding, default widths
// and the beats-per-vector derivation.
package ndp_axis_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ELEM_W = 16;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_A_PH = 2'd1;
   localparam logic [1:0] ST_B_PH = 2'd2;
   localparam logic [1:0] ST_FIN  = 2'd3;

   function automatic int calc_beats(input int elems, input int elem_w, input int data_w);
      return (elems * elem_w) / data_w;
   endfunction

   function automatic int a_beats_f(input int a_height, input int elem_w, input int data_w);
      return calc_beats(a_height, elem_w, data_w);
   endfunction

   function automatic int b_beats_f(input int b_width, input int elem_w, input int data_w);
      return calc_beats(b_width, elem_w, data_w);
   endfunction

endpackage

// File: rtl/ndp_axis_skid.sv
// Two-entry output register slice; present only when NDP_AXIS_SKID_EN is defined.
// Input ready depends only on local state, which breaks the ready path.
`ifdef NDP_AXIS_SKID_EN
module ndp_axis_skid #(
   parameter int W = 33
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         empty
);

   logic [W-1:0] out_q, sk_q;
   logic         out_v, sk_v;

   assign in_ready  = ~sk_v;
   assign out_data  = out_q;
   assign out_valid = out_v;
   assign empty     = ~out_v & ~sk_v;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_q <= '0;
         sk_q  <= '0;
         out_v <= 1'b0;
         sk_v  <= 1'b0;
      end else if (~out_v | out_ready) begin
         if (sk_v) begin
            out_q <= sk_q;
            out_v <= 1'b1;
            sk_v  <= 1'b0;
         end else begin
            out_v <= in_valid;
            if (in_valid) out_q <= in_data;
         end
      end else if (in_valid & ~sk_v) begin
         // output stalled: park the accepted beat in the second entry
         sk_q <= in_data;
         sk_v <= 1'b1;
      end
   end

endmodule
`endif

// File: rtl/ndp_axis_operand_interleaver.sv
// Merges A-column and B-row AXIS streams into NDP order (A col k, B row k, ...).
// Define NDP_AXIS_SKID_EN to register all m_* outputs through a 2-entry skid slice.
module ndp_axis_operand_interleaver
   import ndp_axis_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ELEM_W   = DEF_ELEM_W,
   parameter int A_HEIGHT = 4,
   parameter int B_WIDTH  = 64,
   parameter int K_W      = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [K_W-1:0]      cfg_k,
   output logic                busy,
   output logic                done,
   input  logic [DATA_W-1:0]   a_tdata,
   input  logic                a_tvalid,
   output logic                a_tready,
   input  logic [DATA_W-1:0]   b_tdata,
   input  logic                b_tvalid,
   output logic                b_tready,
   output logic [DATA_W-1:0]   m_tdata,
   output logic [DATA_W/8-1:0] m_tkeep,
   output logic                m_tlast,
   output logic                m_tvalid,
   input  logic                m_tready
);

   localparam int A_BEATS   = a_beats_f(A_HEIGHT, ELEM_W, DATA_W);
   localparam int B_BEATS   = b_beats_f(B_WIDTH, ELEM_W, DATA_W);
   localparam int MAX_BEATS = (A_BEATS > B_BEATS) ? A_BEATS : B_BEATS;
   localparam int CNT_W     = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

   if (A_BEATS < 1 || B_BEATS < 1 || (DATA_W % ELEM_W) != 0 || (DATA_W % 8) != 0) begin : g_bad_cfg
      $error("ndp_axis_operand_interleaver: illegal DATA_W/ELEM_W/A_HEIGHT/B_WIDTH combination");
   end

   logic [1:0]        state;
   logic [CNT_W-1:0]  beat_cnt;
   logic [K_W-1:0]    k_cnt, k_lat;
   logic              in_a, in_b, a_end, b_end, last_k;
   logic              up_valid, up_ready, up_hs, up_last, fin_ok;
   logic [DATA_W-1:0] up_data;

   assign in_a    = (state == ST_A_PH);
   assign in_b    = (state == ST_B_PH);
   assign a_end   = (beat_cnt == CNT_W'(A_BEATS - 1));
   assign b_end   = (beat_cnt == CNT_W'(B_BEATS - 1));
   assign last_k  = (k_cnt == k_lat - 1'b1);

   // the upstream side of the merge, before the optional output slice
   assign up_valid = (in_a & a_tvalid) | (in_b & b_tvalid);
   assign up_data  = in_a ? a_tdata : (in_b ? b_tdata : '0);
   assign up_last  = in_b & b_end & last_k;
   assign up_hs    = up_valid & up_ready;
   assign a_tready = in_a & up_ready;
   assign b_tready = in_b & up_ready;

   assign done    = (state == ST_FIN) & fin_ok;
   assign busy    = (state != ST_IDLE) & ~done;
   assign m_tkeep = '1;

`ifdef NDP_AXIS_SKID_EN
   logic [DATA_W:0] sk_out;

   ndp_axis_skid #(.W(DATA_W + 1)) u_skid (
      .clk       (clk),
      .reset     (reset),
      .in_data   ({up_last, up_data}),
      .in_valid  (up_valid),
      .in_ready  (up_ready),
      .out_data  (sk_out),
      .out_valid (m_tvalid),
      .out_ready (m_tready),
      .empty     (fin_ok)
   );

   assign m_tlast = sk_out[DATA_W];
   assign m_tdata = sk_out[DATA_W-1:0];
`else
   assign up_ready = m_tready;
   assign m_tvalid = up_valid;
   assign m_tdata  = up_data;
   assign m_tlast  = up_last;
   assign fin_ok   = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         beat_cnt <= '0;
         k_cnt    <= '0;
         k_lat    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (cfg_k != '0) begin
                     k_lat    <= cfg_k;
                     beat_cnt <= '0;
                     k_cnt    <= '0;
                     state    <= ST_A_PH;
                  end else begin
                     state <= ST_FIN;
                  end
               end
            end
            ST_A_PH: begin
               if (up_hs) begin
                  if (a_end) begin
                     beat_cnt <= '0;
                     state    <= ST_B_PH;
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            ST_B_PH: begin
               if (up_hs) begin
                  if (b_end) begin
                     beat_cnt <= '0;
                     if (last_k) begin
                        state <= ST_FIN;
                     end else begin
                        k_cnt <= k_cnt + 1'b1;
                        state <= ST_A_PH;
                     end
                  end else begin
                     beat_cnt <= beat_cnt + 1'b1;
                  end
               end
            end
            // wait here until any registered output has drained
            ST_FIN:  if (fin_ok) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/ndp_axis_operand_interleaver.md
Name: ndp_axis_operand_interleaver

Overview:
- Synthesizable AXI-Stream merger that sits in front of NDP_core's s_axis port.
- Accepts two operand streams: activation columns of A and weight rows of B.
- Emits one stream in NDP order: for each k, the column-k beats of A, then the row-k beats of B; tlast on the final B beat.
- Generalised in bus width, element width, array geometry and a run-time reduction depth K; replaces hand-sequenced feeding.

Parameters:
- DATA_W, 32, AXIS data width in bits; multiple of ELEM_W.
- ELEM_W, 16, operand element width.
- A_HEIGHT, 4, elements per A column (SYS_HEIGHT*ARR_HEIGHT).
- B_WIDTH, 64, elements per B row (SYS_WIDTH*ARR_WIDTH).
- K_W, 8, width of the run-time depth field.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a transfer when idle.
- cfg_k  in  K_W  reduction depth K, sampled on an accepted start.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse after the last beat is accepted downstream.
- a_tdata  in  DATA_W  A column beats.
- a_tvalid  in  1  A beat valid.
- a_tready  out  1  A beat ready.
- b_tdata  in  DATA_W  B row beats.
- b_tvalid  in  1  B beat valid.
- b_tready  out  1  B beat ready.
- m_tdata  out  DATA_W  merged stream data.
- m_tkeep  out  DATA_W/8  byte keep; all ones.
- m_tlast  out  1  high on the final beat of the transfer.
- m_tvalid  out  1  merged stream valid.
- m_tready  in  1  downstream ready.

Behaviour:
- Derived constants: A_BEATS = A_HEIGHT*ELEM_W/DATA_W; B_BEATS = B_WIDTH*ELEM_W/DATA_W. Each must be at least 1; elaboration fails otherwise.
- Reset state: IDLE. Outputs on reset: busy=0, done=0, a_tready=0, b_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0. Counters cleared.
- Reset mid-transfer: aborts the transfer. No done pulse; partially sent beats are not replayed.
- FSM states: IDLE, A_PH, B_PH, FIN.
  - IDLE: start=1 with cfg_k!=0 latches K, clears beat_cnt and k_cnt, then goes to A_PH.
  - IDLE: start=1 with cfg_k==0 goes to FIN with no beats.
  - IDLE: start while busy is ignored.
  - A_PH: each downstream handshake increments beat_cnt. At A_BEATS-1, go to B_PH and clear beat_cnt.
  - B_PH: each handshake increments beat_cnt. At B_BEATS-1:
    - if k_cnt==K-1, go to FIN;
    - else increment k_cnt, clear beat_cnt and go to A_PH.
  - FIN: done=1 for one cycle, then IDLE.
- Forwarding without the skid option is combinational pass-through:
  - A_PH: m_tvalid=a_tvalid, m_tdata=a_tdata, a_tready=m_tready, b_tready=0.
  - B_PH: mirrored, driven from the B stream.
  - IDLE and FIN: both inputs not ready and m_tvalid=0.
  - Zero-latency path from input to output.
- m_tlast=1 only in B_PH when beat_cnt==B_BEATS-1 and k_cnt==K-1.
- AXIS rules:
  - m_tvalid never depends on m_tready.
  - Once asserted, data and tvalid hold until the handshake.
  - Input beats arriving in the wrong phase are stalled, never dropped.
- Simultaneous start and reset: reset wins.
- busy falls in the same cycle done rises.
- Total beats per transfer = K*(A_BEATS+B_BEATS).

Optional Feature:
- NDP_AXIS_SKID_EN defined: a 2-entry skid buffer sits on the output.
  - All m_* outputs are registered; 1-cycle latency.
  - Input tready is driven from buffer space, so no combinational path from m_tready to a_tready/b_tready.
  - Full throughput under continuous ready.
  - done is asserted only after the buffer drains the tlast beat.
- Undefined: combinational pass-through as described in Behaviour.

Decomposition:
- Package ndp_axis_pkg holds:
  - FSM state encoding (IDLE/A_PH/B_PH/FIN);
  - A_BEATS/B_BEATS derivation functions;
  - default DATA_W/ELEM_W constants.
- Natural sub-module: ndp_axis_skid, the 2-entry register slice, instantiated only under NDP_AXIS_SKID_EN.

Test Plan:
- Default params, K=21, both inputs always valid, m_tready=1 -> 714 beats. A beats appear at indices 34k and 34k+1; m_tlast only on beat 713; done one cycle after it (two with skid).
- Random m_tready (50%) and random input valids, K=5 -> 170 beats in order, data matches a per-stream scoreboard, no duplicates or drops, tvalid/tdata stable while stalled.
- cfg_k=0 start -> no m_tvalid; done pulses once; busy stays 0; returns to IDLE.
- Reset asserted at beat 40 of a K=21 transfer -> next cycle all outputs 0 and no done; a new start with K=1 then yields exactly 34 beats with tlast on the 34th.
- Start re-pulsed while busy with cfg_k=3 -> ignored; the original K=21 count is preserved.
- Override DATA_W=64, A_HEIGHT=8, B_WIDTH=16, K=2 -> A_BEATS=2, B_BEATS=4, 12 beats total, m_tkeep=8'hFF.
